// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, signed or unsigned, one quotient bit
// per clock. Divide-by-zero and signed overflow are resolved in SETUP and skip
// the iterative phase entirely.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload until that edge, and ready never
// depends combinationally on valid.
module div_seq #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sgn,
  input  logic [W-1:0] divd,
  input  logic [W-1:0] dvsr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         dbz,
  output logic         ovf,
  output logic [2:0]   dbg_state
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CALC  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // latched operands
  logic         r_sgn;
  logic [W-1:0] r_divd;
  logic [W-1:0] r_dvsr;

  // iteration state
  logic         r_neg_q;
  logic         r_neg_r;
  logic [W-1:0] r_acc;   // shifts dividend out at the top, quotient in at the bottom
  logic [W-1:0] r_den;
  logic [W:0]   r_prem;  // partial remainder, one spare bit so the shift never loses a carry
  logic [CW-1:0] r_cnt;

  // result registers
  logic [W-1:0] r_quo;
  logic [W-1:0] r_rem;
  logic         r_dbz;
  logic         r_ovf;

  // combinational helpers
  logic         w_divd_neg;
  logic         w_dvsr_neg;
  logic [W-1:0] w_divd_abs;
  logic [W-1:0] w_dvsr_abs;
  logic         w_is_dbz;
  logic         w_is_ovf;
  logic [W+1:0] w_shift;
  logic [W:0]   w_sub;
  logic         w_ge;
  logic         w_cnt_last;

  assign w_divd_neg = r_sgn & r_divd[W-1];
  assign w_dvsr_neg = r_sgn & r_dvsr[W-1];
  assign w_divd_abs = w_divd_neg ? ((~r_divd) + ONE) : r_divd;
  assign w_dvsr_abs = w_dvsr_neg ? ((~r_dvsr) + ONE) : r_dvsr;
  assign w_is_dbz   = (r_dvsr == '0);
  assign w_is_ovf   = r_sgn && (r_divd == MOST_NEG) && (r_dvsr == '1);

  // restoring step: shift next dividend bit into the remainder and trial-subtract
  assign w_shift    = {r_prem, r_acc[W-1]};
  assign w_ge       = (w_shift >= {2'b00, r_den});
  assign w_sub      = w_shift[W:0] - {1'b0, r_den};
  assign w_cnt_last = (r_cnt == CW'(1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SETUP;
      end
      SETUP: begin
        if (w_is_dbz || w_is_ovf) w_next = DONE;
        else                      w_next = CALC;
      end
      CALC: begin
        if (w_cnt_last) w_next = FIX;
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // datapath: operand capture, iteration and result formation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sgn   <= 1'b0;
      r_divd  <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_acc   <= '0;
      r_den   <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sgn  <= sgn;
            r_divd <= divd;
            r_dvsr <= dvsr;
          end
        end
        SETUP: begin
          r_neg_q <= w_divd_neg ^ w_dvsr_neg;
          r_neg_r <= w_divd_neg;
          r_acc   <= w_divd_abs;
          r_den   <= w_dvsr_abs;
          r_prem  <= '0;
          if (w_is_dbz) begin
            r_quo <= '1;
            r_rem <= r_divd;
            r_dbz <= 1'b1;
            r_ovf <= 1'b0;
            r_cnt <= '0;
          end else if (w_is_ovf) begin
            r_quo <= MOST_NEG;
            r_rem <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            r_cnt <= CW'(W);
          end
        end
        CALC: begin
          r_prem <= w_ge ? w_sub : w_shift[W:0];
          r_acc  <= {r_acc[W-2:0], w_ge};
          r_cnt  <= r_cnt - CW'(1);
        end
        FIX: begin
          r_quo <= r_neg_q ? ((~r_acc) + ONE) : r_acc;
          r_rem <= r_neg_r ? ((~r_prem[W-1:0]) + ONE) : r_prem[W-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign quo       = r_quo;
  assign rem       = r_rem;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule
